mem_burst_master: RTL and testbench

- Initiator-side burst controller that drives the single-port memory interface (we / addr / wrData / rdData) on behalf of a client.
- Accepts one burst command at a time and streams write beats in, or read beats out, over valid/ready handshakes.
- Generates sequential memory addresses; sits between client logic and any memory instance with write-on-clock-edge, combinational read.

---
 rtl/mem_burst_master.sv | 177 +++++++++++++++++
 tb/tb_mem_burst_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// ---------------------------------------------------------------------------
// mem_burst_master
//
// Initiator-side burst controller for a single-port memory with a
// write-on-clock-edge, combinational-read interface. A client issues one
// burst command at a time (start address, beats-minus-one, direction).
// Write beats are then streamed in, or read beats streamed out, over
// valid/ready handshakes. Addresses advance sequentially and wrap modulo
// the memory size.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_write, cmd_addr, cmd_len
//   wr_data/wr_valid/wr_ready  write beat stream (client -> memory)
//   rd_data/rd_valid/rd_ready  read beat stream (memory -> client), registered
//   mem_we/mem_addr/mem_wrData registered memory drive
//   mem_rdData               combinational memory read data for mem_addr
//   busy                     controller not idle
//   done                     one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module mem_burst_master #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [DEPTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             mem_we,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wrData,
    input  logic [WIDTH-1:0] mem_rdData,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WFLUSH = 3'd2,
        S_READ   = 3'd3,
        S_RDRAIN = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] addr_q, addr_d;        // next write-beat address
    logic [LEN_W-1:0] cnt_q, cnt_d;          // beats remaining minus one
    logic             mem_we_q, mem_we_d;
    logic [DEPTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wrdata_q, mem_wrdata_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrdata_q <= mem_wrdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        mem_we_d     = 1'b0;            // write enable is a per-beat pulse
        mem_addr_d   = mem_addr_q;
        mem_wrdata_d = mem_wrdata_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        done_d       = 1'b0;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        // Reads present the first address right away so
                        // mem_rdData is valid in the first READ cycle.
                        mem_addr_d = cmd_addr;
                        state_d    = S_READ;
                    end
                end
            end

            S_WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_wrdata_d = wr_data;
                    addr_d       = addr_q + DEPTH'(1);
                    cnt_d        = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_WFLUSH;
                    end
                end
            end

            S_WFLUSH: begin
                // The last beat's mem_we is on the bus this cycle; the
                // memory commits it at this edge, so the burst is complete.
                state_d = S_IDLE;
                done_d  = 1'b1;
            end

            S_READ: begin
                // Output register refills when empty or being drained,
                // giving one beat per cycle while rd_ready stays high.
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d  = mem_rdData;
                    rd_valid_d = 1'b1;
                    mem_addr_d = mem_addr_q + DEPTH'(1);
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_RDRAIN;
                    end
                end
            end

            S_RDRAIN: begin
                // rd_valid is always set here; wait for the last handshake.
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wrData = mem_wrdata_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_burst_master.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_master
//
// Directed bench for mem_burst_master with a 16 x 8 memory model attached
// to the memory port (write on clock edge, combinational read). Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_burst_master;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wrData;
    logic [7:0] mem_rdData;
    logic       busy;
    logic       done;

    int checks = 0;
    int passed = 0;

    logic [7:0] mem_model [16];
    logic [7:0] wdat [16];      // write beat data for the next write burst
    logic [7:0] rexp [16];      // expected read beats for the next read burst
    logic       rpat [16];      // rd_ready pattern; 1 after the pattern ends
    int         rpat_n;

    mem_burst_master #(.WIDTH(8), .DEPTH(4), .LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wrData (mem_wrData),
        .mem_rdData (mem_rdData),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wrData;
    end
    assign mem_rdData = mem_model[mem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 4'h0 || mem_wrData !== 8'h00 ||
            rd_data !== 8'h00 || rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_outputs: we=%b addr=%h wd=%h rd=%h rv=%b done=%b busy=%b, required all zero",
                     mem_we, mem_addr, mem_wrData, rd_data, rd_valid, done, busy);
        end else passed++;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || wr_ready !== 1'b0) begin
            $display("FAIL reset_release: cmd_ready=%b wr_ready=%b, required 1 0", cmd_ready, wr_ready);
        end else passed++;
        $display("reset: released, cmd_ready=%b", cmd_ready);
    endtask

    // Write burst with 'gap' idle cycles before each beat. Returns in the
    // done cycle so the caller can issue the next command immediately.
    task automatic write_burst(input logic [3:0] addr, input logic [3:0] len,
                               input int gap, input string name);
        logic [3:0] ea;
        int we_cycles;
        we_cycles = 0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL %s_cmd_ready: got %b, required 1", name, cmd_ready);
        end else passed++;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
        step();
        cmd_valid = 1'b0; cmd_addr = 4'h0; cmd_len = 4'h0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            $display("FAIL %s_accept: busy=%b done=%b cmd_ready=%b, required 1 0 0", name, busy, done, cmd_ready);
        end else passed++;
        for (int i = 0; i <= int'(len); i++) begin
            for (int g = 0; g < gap; g++) begin
                wr_valid = 1'b0;
                step();
                checks++;
                if (mem_we !== 1'b0) begin
                    $display("FAIL %s_gap_we: beat %0d gap %0d mem_we=%b, required 0", name, i, g, mem_we);
                end else passed++;
            end
            checks++;
            if (wr_ready !== 1'b1) begin
                $display("FAIL %s_wr_ready: beat %0d got %b, required 1", name, i, wr_ready);
            end else passed++;
            wr_valid = 1'b1;
            wr_data  = wdat[i];
            step();
            ea = addr + 4'(i);
            if (mem_we === 1'b1) we_cycles++;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ea || mem_wrData !== wdat[i]) begin
                $display("FAIL %s_beat%0d: we=%b addr=%h data=%h, required 1 %h %h",
                         name, i, mem_we, mem_addr, mem_wrData, ea, wdat[i]);
            end else passed++;
            $display("%s: beat %0d mem_we=%b mem_addr=%h mem_wrData=%h", name, i, mem_we, mem_addr, mem_wrData);
        end
        wr_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || wr_ready !== 1'b0) begin
            $display("FAIL %s_flush: done=%b wr_ready=%b, required 0 0", name, done, wr_ready);
        end else passed++;
        step();
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL %s_done: done=%b we=%b busy=%b cmd_ready=%b, required 1 0 0 1",
                     name, done, mem_we, busy, cmd_ready);
        end else passed++;
        checks++;
        if (we_cycles != int'(len) + 1) begin
            $display("FAIL %s_we_count: got %0d, required %0d", name, we_cycles, int'(len) + 1);
        end else passed++;
        for (int i = 0; i <= int'(len); i++) begin
            ea = addr + 4'(i);
            checks++;
            if (mem_model[ea] !== wdat[i]) begin
                $display("FAIL %s_mem[%h]: got %h, required %h", name, ea, mem_model[ea], wdat[i]);
            end else passed++;
        end
        $display("%s: done, %0d beats written", name, we_cycles);
    endtask

    // Read burst with rd_ready following rpat; checks data order, stability
    // under backpressure, mem_we low, and the done pulse after the last beat.
    task automatic read_burst(input logic [3:0] addr, input logic [3:0] len,
                              input bit full_rate, input string name);
        int  h;
        int  cyc;
        bit  last_hs;
        bit  prev_hold;
        bit  finished;
        logic [7:0] prev_data;
        h = 0; prev_hold = 1'b0; prev_data = 8'h00; finished = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL %s_cmd_ready: got %b, required 1", name, cmd_ready);
        end else passed++;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
        step();
        cmd_valid = 1'b0; cmd_addr = 4'h0; cmd_len = 4'h0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || rd_valid !== 1'b0 || mem_addr !== addr) begin
            $display("FAIL %s_accept: busy=%b done=%b rv=%b addr=%h, required 1 0 0 %h",
                     name, busy, done, rd_valid, mem_addr, addr);
        end else passed++;
        for (cyc = 0; cyc < 40; cyc++) begin
            rd_ready = (cyc < rpat_n) ? rpat[cyc] : 1'b1;
            last_hs = 1'b0;
            checks++;
            if (mem_we !== 1'b0) begin
                $display("FAIL %s_we_low: cycle %0d mem_we=%b, required 0", name, cyc, mem_we);
            end else passed++;
            if (prev_hold) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    $display("FAIL %s_hold: cycle %0d rv=%b data=%h, required 1 %h",
                             name, cyc, rd_valid, rd_data, prev_data);
                end else passed++;
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                checks++;
                if (rd_data !== rexp[h]) begin
                    $display("FAIL %s_beat%0d: rd_data=%h, required %h", name, h, rd_data, rexp[h]);
                end else passed++;
                $display("%s: beat %0d rd_data=%h (cycle %0d)", name, h, rd_data, cyc);
                h++;
                last_hs = (h == int'(len) + 1);
            end
            prev_hold = (rd_valid === 1'b1) && (rd_ready === 1'b0);
            prev_data = rd_data;
            step();
            if (last_hs) begin
                finished = 1'b1;
                break;
            end
            checks++;
            if (done !== 1'b0) begin
                $display("FAIL %s_early_done: cycle %0d done=%b, required 0", name, cyc, done);
            end else passed++;
        end
        rd_ready = 1'b0;
        checks++;
        if (!finished) begin
            $display("FAIL %s_timeout: %0d handshakes, required %0d", name, h, int'(len) + 1);
        end else if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL %s_done: done=%b busy=%b cmd_ready=%b, required 1 0 1", name, done, busy, cmd_ready);
        end else passed++;
        if (full_rate) begin
            checks++;
            if (cyc != int'(len) + 1) begin
                $display("FAIL %s_throughput: last handshake cycle %0d, required %0d", name, cyc, int'(len) + 1);
            end else passed++;
        end
        $display("%s: done, %0d handshakes", name, h);
    endtask

    task automatic test_write_basic();
        wdat[0] = 8'hA1; wdat[1] = 8'hB2; wdat[2] = 8'hC3; wdat[3] = 8'hD4;
        write_burst(4'h2, 4'd3, 0, "write_basic");
    endtask

    task automatic test_read_basic();
        rexp[0] = 8'hA1; rexp[1] = 8'hB2; rexp[2] = 8'hC3; rexp[3] = 8'hD4;
        rpat_n = 0;
        read_burst(4'h2, 4'd3, 1'b1, "read_basic");
    endtask

    task automatic test_wrap();
        wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03; wdat[3] = 8'h04;
        write_burst(4'hE, 4'd3, 0, "wrap_write");
        rexp[0] = 8'h01; rexp[1] = 8'h02; rexp[2] = 8'h03; rexp[3] = 8'h04;
        rpat_n = 0;
        read_burst(4'hE, 4'd3, 1'b1, "wrap_read");
    endtask

    task automatic test_backpressure();
        // Addresses 2,3,4 still hold A1,B2,C3 from the basic write.
        rexp[0] = 8'hA1; rexp[1] = 8'hB2; rexp[2] = 8'hC3;
        rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0;
        rpat[3] = 1'b1; rpat[4] = 1'b0; rpat[5] = 1'b1;
        rpat_n = 6;
        read_burst(4'h2, 4'd2, 1'b0, "backpressure");
    endtask

    task automatic test_gapped_and_single();
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
        write_burst(4'h8, 4'd2, 2, "gapped_write");
        wdat[0] = 8'h5A;
        write_burst(4'h7, 4'd0, 0, "single_write");
        // Issued in the done cycle of the single write.
        rexp[0] = 8'h5A;
        rpat_n = 0;
        read_burst(4'h7, 4'd0, 1'b1, "single_read");
    endtask

    task automatic test_reset_mid_burst();
        int done_seen;
        done_seen = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_len = 4'd7;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hE0 + 8'(i);
            step();
        end
        checks++;
        if (mem_we !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL rst_mid_pre: we=%b busy=%b, required 1 1", mem_we, busy);
        end else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rst_mid_async: we=%b rv=%b busy=%b done=%b, required 0 0 0 0",
                     mem_we, rd_valid, busy, done);
        end else passed++;
        $display("rst_mid: reset asserted mid-burst, mem_we=%b busy=%b", mem_we, busy);
        wr_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done !== 1'b0 || mem_we !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            $display("FAIL rst_mid_quiet: %0d cycles with done or mem_we after reset, required 0", done_seen);
        end else passed++;
        checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL rst_mid_cmd_ready: got %b, required 1", cmd_ready);
        end else passed++;
        $display("rst_mid: released, cmd_ready=%b", cmd_ready);
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_len = 4'h0;
        wr_data = 8'h00; wr_valid = 1'b0; rd_ready = 1'b0;
        rpat_n = 0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrap();
        test_backpressure();
        test_gapped_and_single();
        step();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
